// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and FSM state type for the registered execute-stage ALU.
package alu_pipe_pkg;

    localparam logic [3:0] OP_ROL = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_ROR = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle over WIDTH cycles,
// sign handled by multiplying magnitudes and negating the product at the end.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             take,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [PW-1:0]    HALF     = PW'(1) << (WIDTH - 1);

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic             run_reg;
    logic             neg_reg;
    logic             sign_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [PW-1:0]    acc_reg;
    logic [PW-1:0]    mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [PW-1:0]    acc_sum;

    assign a_neg = sign && a[WIDTH-1];
    assign b_neg = sign && b[WIDTH-1];
    assign mag_a = a_neg ? -a : a;
    assign mag_b = b_neg ? -b : b;

    // The final partial product is folded in combinationally so the result
    // is ready in the last counted cycle and can be held there on a stall.
    assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign done    = run_reg && (cnt_reg == CNT_LAST);
    assign prod_lo = neg_reg ? -acc_sum[WIDTH-1:0] : acc_sum[WIDTH-1:0];

    // Signed range is asymmetric: a negative product may reach 2^(WIDTH-1).
    assign ovf = sign_reg ? (neg_reg ? (acc_sum > HALF) : (acc_sum >= HALF))
                          : (acc_sum[PW-1:WIDTH] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_reg    <= 1'b0;
            neg_reg    <= 1'b0;
            sign_reg   <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start) begin
            run_reg    <= 1'b1;
            neg_reg    <= a_neg ^ b_neg;
            sign_reg   <= sign;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
            mplier_reg <= mag_b;
        end else if (run_reg) begin
            if (cnt_reg != CNT_LAST) begin
                acc_reg    <= acc_sum;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + 1'b1;
            end else if (take) begin
                run_reg <= 1'b0;
                cnt_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit execute-stage ALU with valid/ready handshakes.
// Define ALU_PIPE_MUL_EN to build the iterative multiplier; otherwise Op=1000 is reserved.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             Z,
    output logic             N,
    output logic             P,
    output logic             c_out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int MSB   = WIDTH - 1;

    state_t state_reg;
    state_t state_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_reg;
    logic             ofl_reg;
    logic             z_reg;
    logic             n_reg;
    logic             p_reg;
    logic             c_reg;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CNT_W-1:0] sh_cnt;
    logic [CNT_W:0]   sh_inv;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ofl;
    logic             alu_c;

    logic             accept;
    logic             is_mul_op;
    logic             single_fire;
    logic             mul_fire;
    logic             load;
    logic             mul_done;
    logic             mul_ovf;
    logic [WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0] res_d;
    logic             ofl_d;
    logic             c_d;

    assign op_a    = invA ? ~A : A;
    assign op_b    = invB ? ~B : B;
    assign sh_cnt  = B[CNT_W-1:0];
    // A count of zero makes sh_inv equal WIDTH, so the wrap-around term vanishes.
    assign sh_inv  = (CNT_W + 1)'(WIDTH) - {1'b0, sh_cnt};
    assign sum_ext = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, Cin};

    always_comb begin
        alu_res = '0;
        alu_ofl = 1'b0;
        alu_c   = 1'b0;
        case (Op)
            OP_ROL: alu_res = (op_a << sh_cnt) | (op_a >> sh_inv);
            OP_SLL: alu_res = op_a << sh_cnt;
            OP_ROR: alu_res = (op_a >> sh_cnt) | (op_a << sh_inv);
            OP_SRL: alu_res = op_a >> sh_cnt;
            OP_ADD: begin
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_ofl = sign ? ((op_a[MSB] == op_b[MSB]) && (sum_ext[MSB] != op_a[MSB]))
                               : sum_ext[WIDTH];
            end
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_AND: alu_res = op_a & op_b;
            default: alu_ofl = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    assign is_mul_op = (Op == OP_MUL);

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_mul_op),
        .take   (mul_fire),
        .a      (op_a),
        .b      (op_b),
        .sign   (sign),
        .done   (mul_done),
        .prod_lo(mul_prod),
        .ovf    (mul_ovf)
    );
`else
    assign is_mul_op = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
    assign mul_ovf   = 1'b0;
`endif

    assign in_ready    = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
    assign accept      = in_valid && in_ready;
    assign single_fire = accept && !is_mul_op;
    // A finished multiply waits in ST_MUL until the result register is free.
    assign mul_fire    = (state_reg == ST_MUL) && mul_done && (!out_valid_reg || out_ready);
    assign load        = single_fire || mul_fire;

    assign res_d = mul_fire ? mul_prod : alu_res;
    assign ofl_d = mul_fire ? mul_ovf  : alu_ofl;
    assign c_d   = mul_fire ? 1'b0     : alu_c;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && is_mul_op) state_next = ST_MUL;
            ST_MUL:  if (mul_fire)            state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            ofl_reg       <= 1'b0;
            z_reg         <= 1'b0;
            n_reg         <= 1'b0;
            p_reg         <= 1'b0;
            c_reg         <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                out_valid_reg <= 1'b1;
                out_reg       <= res_d;
                ofl_reg       <= ofl_d;
                z_reg         <= (res_d == '0);
                n_reg         <= res_d[MSB];
                p_reg         <= (res_d != '0) && !res_d[MSB];
                c_reg         <= c_d;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign Out       = out_reg;
    assign Ofl       = ofl_reg;
    assign Z         = z_reg;
    assign N         = n_reg;
    assign P         = p_reg;
    assign c_out     = c_reg;
    assign busy      = (state_reg == ST_MUL);

endmodule
